// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the program counter and the IF/ID pipeline
// register. The instruction ROM is read combinationally at the current PC and
// the result is captured into IF/ID on the next rising edge.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_pll_lock,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc_plus4,
    output logic        o_if_id_valid,
    output logic        o_misalign,
    output logic [31:0] o_fetch_count
);

    logic [31:0] pc_q,       pc_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc4_q,   id_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] count_q,    count_d;
    logic [31:0] pc_plus4_s;

    assign pc_plus4_s = pc_q + 32'd4;

    // Next-state selection: redirect beats lock loss, lock loss beats stall,
    // stall beats a normal fetch. Reset is applied in the register block.
    always_comb begin
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        misalign_d = misalign_q;
        count_d    = count_q;
        if (i_redirect) begin
            // Wrong-path instruction in IF/ID is discarded; target is word aligned.
            pc_d       = {i_redirect_pc[31:2], 2'b00};
            id_pc_d    = 32'h0000_0000;
            id_instr_d = NOP_INSTR;
            id_pc4_d   = 32'h0000_0000;
            id_valid_d = 1'b0;
            if (i_redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end else begin
                misalign_d = misalign_q;
            end
        end else if (!i_pll_lock) begin
            // PC holds so fetch resumes at the same address once lock returns.
            id_pc_d    = 32'h0000_0000;
            id_instr_d = NOP_INSTR;
            id_pc4_d   = 32'h0000_0000;
            id_valid_d = 1'b0;
        end else if (i_stall) begin
            // Everything holds; defaults already express that.
            pc_d = pc_q;
        end else begin
            id_pc_d    = pc_q;
            id_instr_d = i_imem_rdata;
            id_pc4_d   = pc_plus4_s;
            id_valid_d = 1'b1;
            pc_d       = pc_plus4_s;
            count_d    = count_q + 32'd1;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            id_pc_q    <= 32'h0000_0000;
            id_instr_q <= NOP_INSTR;
            id_pc4_q   <= 32'h0000_0000;
            id_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= 32'h0000_0000;
        end else begin
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    assign o_imem_addr      = pc_q;
    assign o_if_id_pc       = id_pc_q;
    assign o_if_id_instr    = id_instr_q;
    assign o_if_id_pc_plus4 = id_pc4_q;
    assign o_if_id_valid    = id_valid_q;
    assign o_misalign       = misalign_q;
    assign o_fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed test-plan sequences followed by random
// stimulus, checked by a scoreboard fed from a behavioural reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pll_lock = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_pc, id_instr, id_pc4, fetch_count;
    logic        id_valid, misalign;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
        logic [31:0] addr;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_id_pc, m_id_instr, m_id_pc4, m_cnt;
    logic        m_id_valid, m_mis;

    always #5 clk = ~clk;

    // ROM contents: an address-dependent pattern so every word is distinct.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234} + (a * 32'd7);
    endfunction

    assign imem_rdata = rom_word(imem_addr);

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_pll_lock       (pll_lock),
        .i_stall          (stall),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc),
        .o_imem_addr      (imem_addr),
        .i_imem_rdata     (imem_rdata),
        .o_if_id_pc       (id_pc),
        .o_if_id_instr    (id_instr),
        .o_if_id_pc_plus4 (id_pc4),
        .o_if_id_valid    (id_valid),
        .o_misalign       (misalign),
        .o_fetch_count    (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, queue the expected result,
    // then return at the following falling edge (after the DUT has updated).
    task automatic cycle(input logic r, input logic lk, input logic st,
                         input logic rd, input logic [31:0] rpc);
        exp_t e;
        rst = r; pll_lock = lk; stall = st; redirect = rd; redirect_pc = rpc;
        if (r) begin
            m_pc = RESET_PC; m_id_pc = 32'd0; m_id_instr = NOP_INSTR;
            m_id_pc4 = 32'd0; m_id_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'd0;
        end else if (rd) begin
            m_pc = rpc & 32'hFFFF_FFFC;
            m_id_pc = 32'd0; m_id_instr = NOP_INSTR; m_id_pc4 = 32'd0; m_id_valid = 1'b0;
            if (rpc % 32'd4 != 32'd0) m_mis = 1'b1;
        end else if (!lk) begin
            m_id_pc = 32'd0; m_id_instr = NOP_INSTR; m_id_pc4 = 32'd0; m_id_valid = 1'b0;
        end else if (!st) begin
            m_id_pc = m_pc; m_id_instr = rom_word(m_pc); m_id_pc4 = m_pc + 32'd4;
            m_id_valid = 1'b1; m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
        end
        e.pc = m_id_pc; e.instr = m_id_instr; e.pc4 = m_id_pc4; e.valid = m_id_valid;
        e.mis = m_mis; e.cnt = m_cnt; e.addr = m_pc;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic fetch(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    // Monitor: after every rising edge, compare DUT outputs with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("if_id_pc", id_pc, e.pc);
                chk("if_id_instr", id_instr, e.instr);
                chk("if_id_pc_plus4", id_pc4, e.pc4);
                chk("if_id_valid", {31'd0, id_valid}, {31'd0, e.valid});
                chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
                chk("fetch_count", fetch_count, e.cnt);
                chk("imem_addr", imem_addr, e.addr);
            end
        end
    end

    // Stimulus
    initial begin
        logic [31:0] held;
        int          drain;

        // Reset then four free fetches
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0040_0000);
        fetch(4);
        chk("free_last_pc", id_pc, 32'h0040_000C);
        chk("free_count", fetch_count, 32'd4);

        // Stall for 3 cycles after the 2nd fetch
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        fetch(2);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
            chk("stall_pc", id_pc, 32'h0040_0004);
            chk("stall_addr", imem_addr, 32'h0040_0008);
        end
        fetch(1);
        chk("post_stall_pc", id_pc, 32'h0040_0008);
        chk("post_stall_cnt", fetch_count, 32'd3);

        // Redirect overriding a simultaneous stall
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0040);
        chk("redir_bubble_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_bubble_instr", id_instr, 32'h0000_0013);
        fetch(1);
        chk("redir_target_pc", id_pc, 32'h0040_0040);
        chk("redir_target_valid", {31'd0, id_valid}, 32'd1);

        // Misaligned redirect: sticky flag
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0022);
        chk("mis_addr", imem_addr, 32'h0040_0020);
        chk("mis_set", {31'd0, misalign}, 32'd1);
        fetch(10);
        chk("mis_sticky", {31'd0, misalign}, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("mis_cleared", {31'd0, misalign}, 32'd0);

        // Lock low for 2 cycles mid-run
        fetch(3);
        held = imem_addr;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            chk("lock_bubble", {31'd0, id_valid}, 32'd0);
            chk("lock_hold_addr", imem_addr, held);
        end
        fetch(1);
        chk("lock_resume_pc", id_pc, held);

        // Wrap-around at the top of the address space
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        fetch(1);
        chk("wrap_pc0", id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", id_pc4, 32'h0000_0000);
        fetch(1);
        chk("wrap_pc1", id_pc, 32'h0000_0000);

        // Random phase
        for (int i = 0; i < 400; i++) begin
            logic r, lk, st, rd;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 49) == 0);
            lk  = ($urandom_range(0, 9) != 0);
            st  = ($urandom_range(0, 4) == 0);
            rd  = ($urandom_range(0, 11) == 0);
            rpc = $urandom();
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            cycle(r, lk, st, rd, rpc);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

        // Let the monitor drain the scoreboard (bounded)
        drain = 0;
        while (sb_q.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        if (sb_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
